// File: rtl/spi_master_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_master_param
//
// Parameterised SPI master. It sends one framed transfer of the form
// command, optional address, then data. While the data field is on mosi, the
// same number of bits are captured from miso.
//
// A transfer runs through these phases:
//   IDLE -> SETUP -> CMD -> ADDR (only when addr_en) -> DATA -> HOLD -> IDLE
// SETUP and HOLD each last CLK_DIV cycles, with sck held at CPOL.
// Each bit lasts 2*CLK_DIV cycles:
//   - the leading sck edge comes after CLK_DIV cycles;
//   - the trailing edge comes after 2*CLK_DIV cycles.
//
// Parameters
//   CMD_W   command field width
//   ADDR_W  address field width
//   DATA_W  data field width (transmit and capture)
//   CLK_DIV sck half-period in clk cycles
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle request, accepted only in IDLE
//   mode           {CPOL,CPHA}, latched on accept
//   addr_en        include the address phase, latched on accept
//   ext_command_in command field, latched on accept
//   ext_address_in address field, latched on accept
//   ext_data_in    data field, latched on accept
//   cs             chip select, active low
//   sck            serial clock
//   mosi           master out; 0 whenever cs is high
//   miso           master in
//   ext_data_out   captured data; updates in the cycle cs returns high
//   busy           high while a transfer is in progress
//   done           one-cycle pulse as cs returns high
//
// Build option
//   SPI_MASTER_PARAM_LSB_FIRST_EN: when defined, every field is sent and
//   captured LSB first. Timing is unchanged.
// -----------------------------------------------------------------------------
module spi_master_param #(
  parameter int CMD_W   = 8,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              addr_en,
  input  logic [CMD_W-1:0]  ext_command_in,
  input  logic [ADDR_W-1:0] ext_address_in,
  input  logic [DATA_W-1:0] ext_data_in,
  output logic              cs,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] ext_data_out,
  output logic              busy,
  output logic              done
);

  localparam int TOT_W  = CMD_W + ADDR_W + DATA_W;
  localparam int MAX_CA = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
  localparam int MAX_W  = (MAX_CA > DATA_W) ? MAX_CA : DATA_W;
  localparam int BW     = $clog2(MAX_W + 1);
  localparam int CW     = $clog2(2 * CLK_DIV + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DATA,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [BW-1:0]     fw_last;
  logic              cpol_q, cpha_q, addr_en_q;
  logic              accept, in_bit, lead, trail, last_bit;
  logic              setup_end, hold_end, final_bit;
  logic              present_bit, sample;
  logic [TOT_W-1:0]  tx_q, tx_load;
  logic [DATA_W-1:0] rx_q, rx_next;
  logic [CMD_W-1:0]  cmd_ord;
  logic [ADDR_W-1:0] addr_ord;
  logic [DATA_W-1:0] data_ord;

  // Transmit word in send order: the word is always shifted out from its MSB.
  // When addr_en is low the address slot is dropped, data moves up behind the
  // command, and the tail is zero-padded; those padding bits are never sent.
  always_comb begin
    cmd_ord  = ext_command_in;
    addr_ord = ext_address_in;
    data_ord = ext_data_in;
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
    for (int i = 0; i < CMD_W; i++)  cmd_ord[i]  = ext_command_in[CMD_W-1-i];
    for (int i = 0; i < ADDR_W; i++) addr_ord[i] = ext_address_in[ADDR_W-1-i];
    for (int i = 0; i < DATA_W; i++) data_ord[i] = ext_data_in[DATA_W-1-i];
`endif
    if (addr_en) tx_load = {cmd_ord, addr_ord, data_ord};
    else         tx_load = {cmd_ord, data_ord, {ADDR_W{1'b0}}};
  end

  always_comb begin
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
    rx_next = (rx_q >> 1) | (DATA_W'(miso) << (DATA_W - 1));
`else
    rx_next = (rx_q << 1) | DATA_W'(miso);
`endif
  end

  // Phase counter, bit counter and next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    fw_last   = '0;
    lead      = 1'b0;
    trail     = 1'b0;
    last_bit  = 1'b0;

    case (state_q)
      CMD:     fw_last = BW'(CMD_W - 1);
      ADDR:    fw_last = BW'(ADDR_W - 1);
      DATA:    fw_last = BW'(DATA_W - 1);
      default: fw_last = '0;
    endcase

    accept    = (state_q == IDLE) && start;
    in_bit    = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    setup_end = (state_q == SETUP) && (cnt_q == HALF_LAST);
    hold_end  = (state_q == HOLD) && (cnt_q == HALF_LAST);

    if (in_bit) begin
      lead     = (cnt_q == HALF_LAST);
      trail    = (cnt_q == FULL_LAST);
      last_bit = (bit_q == fw_last);
    end

    final_bit = (state_q == DATA) && trail && last_bit;

    // CPHA=0 presents the first bit as its period opens, then each following
    // bit on the trailing edge. CPHA=1 presents each bit on the leading edge.
    present_bit = cpha_q ? lead : (setup_end || (trail && !final_bit));
    sample      = (state_q == DATA) && (cpha_q ? trail : lead);

    if (state_q == IDLE) begin
      cnt_d = '0;
      bit_d = '0;
    end else if (setup_end || hold_end || trail) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (trail) bit_d = last_bit ? '0 : bit_q + BW'(1);

    case (state_q)
      IDLE:    if (start)     state_d = SETUP;
      SETUP:   if (setup_end) state_d = CMD;
      CMD:     if (trail && last_bit) state_d = addr_en_q ? ADDR : DATA;
      ADDR:    if (trail && last_bit) state_d = DATA;
      DATA:    if (trail && last_bit) state_d = HOLD;
      HOLD:    if (hold_end)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      bit_q        <= '0;
      cs           <= 1'b1;
      sck          <= 1'b0;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ext_data_out <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      addr_en_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      done  <= 1'b0;

      if (accept) begin
        cs        <= 1'b0;
        busy      <= 1'b1;
        sck       <= mode[1];
        mosi      <= 1'b0;
        cpol_q    <= mode[1];
        cpha_q    <= mode[0];
        addr_en_q <= addr_en;
      end

      if (lead)  sck <= ~cpol_q;
      if (trail) sck <= cpol_q;

      if (present_bit)    mosi <= tx_q[TOT_W-1];
      else if (final_bit) mosi <= 1'b0;

      if (hold_end) begin
        cs           <= 1'b1;
        busy         <= 1'b0;
        done         <= 1'b1;
        mosi         <= 1'b0;
        ext_data_out <= rx_q;
      end
    end
  end

  // Shift registers carry data only and need no reset
  always_ff @(posedge clk) begin
    if (accept)           tx_q <= tx_load;
    else if (present_bit) tx_q <= tx_q << 1;

    if (sample) rx_q <= rx_next;
  end

endmodule
